// File: rtl/conv2d_stream_pkg.sv
// Shared types and helpers for the streaming KxK convolution engine.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   function automatic int acc_width(input int data_w, input int coef_w, input int k);
      return data_w + coef_w + 1 + $clog2(k * k);
   endfunction

   // Clamp a sign-extended value into the signed range of an out_w-bit result.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int out_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/conv2d_stream_if.sv
// Pixel-in / result-out valid-ready streams of the convolution engine.
interface conv2d_stream_if #(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_W-1:0]        in_pix;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [OUT_W-1:0]  out_pix;
   logic                     out_last;

   modport master (
      output in_valid, in_pix, out_ready,
      input  in_ready, out_valid, out_pix, out_last
   );

   modport slave (
      input  in_valid, in_pix, out_ready,
      output in_ready, out_valid, out_pix, out_last
   );
endinterface

// File: rtl/conv2d_stream_line_buffer.sv
// Holds the previous K-1 image rows as one shift chain; taps[j] is the pixel j+1 rows above din.
module line_buffer #(
   parameter  int DATA_W = 8,
   parameter  int IMG_W  = 28,
   parameter  int K      = 3,
   localparam int NTAP   = (K > 1) ? K - 1 : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         hold,
   input  logic [DATA_W-1:0]            din,
   output logic [NTAP-1:0][DATA_W-1:0]  taps
);
   localparam int LEN = NTAP * IMG_W;

   logic [DATA_W-1:0] sr_q [LEN];
   logic [DATA_W-1:0] sr_d [LEN];

   always_comb begin
      sr_d = sr_q;
      if (!hold) begin
         for (int i = LEN - 1; i > 0; i--) sr_d[i] = sr_q[i-1];
         sr_d[0] = din;
      end
   end

   always_comb begin
      taps = '0;
      for (int j = 0; j < NTAP; j++) taps[j] = sr_q[(j + 1) * IMG_W - 1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LEN; i++) sr_q[i] <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end
endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK "valid"-mode convolution: line buffer + window, product stage, reduce/shift/ReLU/saturate stage.
//   state | meaning
//   IDLE  | between frames, coefficient writes accepted
//   RUN   | accepting pixels of the current frame
//   FLUSH | last pixel taken, draining the pipeline
module conv2d_stream import conv_pkg::*; #(
   parameter  int DATA_W  = 8,
   parameter  int COEF_W  = 8,
   parameter  int OUT_W   = 16,
   parameter  int IMG_W   = 28,
   parameter  int IMG_H   = 28,
   parameter  int K       = 3,
   parameter  int SHIFT   = 0,
   parameter  int RELU    = 0,
   localparam int COEF_AW = (K > 1) ? $clog2(K * K) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      coef_we,
   input  logic [COEF_AW-1:0]        coef_addr,
   input  logic signed [COEF_W-1:0]  coef_data,
   output logic                      busy,
   conv2d_stream_if.slave            strm
);
   localparam int ACC_W  = acc_width(DATA_W, COEF_W, K);
   localparam int PROD_W = DATA_W + COEF_W + 1;
   localparam int NK     = K * K;
   localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int NTAP   = (K > 1) ? K - 1 : 1;

   state_e                   state_q, state_d;
   logic [CW-1:0]            col_q, col_d;
   logic [RW-1:0]            row_q, row_d;
   logic signed [COEF_W-1:0] coef_q [NK];
   logic signed [COEF_W-1:0] coef_d [NK];
   logic [DATA_W-1:0]        win_q [K][K];
   logic [DATA_W-1:0]        win_d [K][K];
   logic [DATA_W-1:0]        col_vec [K];
   logic                     v0_q, v0_d, last0_q, last0_d;
   logic signed [PROD_W-1:0] prod_q [NK];
   logic signed [PROD_W-1:0] prod_d [NK];
   logic                     v1_q, v1_d, last1_q, last1_d;
   logic signed [OUT_W-1:0]  out_q, out_d;
   logic                     out_valid_q, out_valid_d;
   logic                     out_last_q, out_last_d;
   logic [NTAP-1:0][DATA_W-1:0] taps;

   logic                     adv, in_ready_w, accept, emit, frame_end;
   logic signed [ACC_W-1:0]  acc, acc_sh;
   logic signed [63:0]       sat;

   assign adv        = !out_valid_q | strm.out_ready;
   assign in_ready_w = (state_q == RUN) & en & adv;
   assign accept     = strm.in_valid & in_ready_w;
   assign emit       = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
   assign frame_end  = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

   assign strm.in_ready  = in_ready_w;
   assign strm.out_valid = out_valid_q;
   assign strm.out_pix   = out_q;
   assign strm.out_last  = out_last_q;
   assign busy           = (state_q != IDLE);

   line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .K(K)) u_line_buffer (
      .clk   (clk),
      .rst_n (rst_n),
      .hold  (!accept),
      .din   (strm.in_pix),
      .taps  (taps)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = RUN;
         RUN:     if (accept && frame_end) state_d = FLUSH;
         FLUSH:   if (!v0_q && !v1_q && adv) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      coef_d = coef_q;
      if ((state_q == IDLE) && coef_we && (int'(coef_addr) < NK)) coef_d[coef_addr] = coef_data;
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = frame_end ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // Window row r sits K-1-r rows above the incoming pixel; the bottom row takes in_pix directly.
   always_comb begin
      for (int r = 0; r < K; r++) begin
         if (r == K - 1) col_vec[r] = strm.in_pix;
         else            col_vec[r] = taps[K - 2 - r];
      end
      win_d = win_q;
      if (accept) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
            win_d[r][K-1] = col_vec[r];
         end
      end
   end

   always_comb begin
      acc = '0;
      for (int i = 0; i < NK; i++) acc = acc + ACC_W'(prod_q[i]);
      acc_sh = acc >>> SHIFT;
      if ((RELU != 0) && (acc_sh < 0)) acc_sh = '0;
      sat = saturate(64'(acc_sh), OUT_W);
   end

   always_comb begin
      v0_d        = v0_q;
      last0_d     = last0_q;
      prod_d      = prod_q;
      v1_d        = v1_q;
      last1_d     = last1_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      if (adv) begin
         v0_d    = accept & emit;
         last0_d = accept & frame_end;
         for (int i = 0; i < NK; i++)
            prod_d[i] = PROD_W'($signed({1'b0, win_q[i / K][i % K]})) * PROD_W'(coef_q[i]);
         v1_d        = v0_q;
         last1_d     = last0_q;
         out_d       = sat[OUT_W-1:0];
         out_valid_d = v1_q;
         out_last_d  = last1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         v0_q        <= 1'b0;
         last0_q     <= 1'b0;
         v1_q        <= 1'b0;
         last1_q     <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         for (int i = 0; i < NK; i++) begin
            coef_q[i] <= '0;
            prod_q[i] <= '0;
         end
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) win_q[r][c] <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         coef_q      <= coef_d;
         win_q       <= win_d;
         v0_q        <= v0_d;
         last0_q     <= last0_d;
         prod_q      <= prod_d;
         v1_q        <= v1_d;
         last1_q     <= last1_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end
endmodule

// File: tb/tb_conv2d_stream.sv
// Three engines (plain, ReLU, SHIFT=4) on a 5x5 frame with a 3x3 kernel, checked against a direct convolution model.
module tb_conv2d_stream;
   localparam int IW = 5, IH = 5, NPIX = IW * IH, NOUT = 9, LIMIT = 600;

   logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, coef_we = 1'b0;
   logic [3:0]  coef_addr = '0;
   logic [7:0]  coef_data = '0;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [7:0]  in_pix = '0;
   logic        busy_b, busy_r, busy_s;
   int          tests = 0, fails = 0;
   int          img [NPIX];
   int          kc [9];
   bit          ab;

   always #5 clk = ~clk;

   conv2d_stream_if #(.DATA_W(8), .OUT_W(16)) if_b (), if_r (), if_s ();

   assign if_b.in_valid = in_valid;  assign if_b.in_pix = in_pix;  assign if_b.out_ready = out_ready;
   assign if_r.in_valid = in_valid;  assign if_r.in_pix = in_pix;  assign if_r.out_ready = out_ready;
   assign if_s.in_valid = in_valid;  assign if_s.in_pix = in_pix;  assign if_s.out_ready = out_ready;

   conv2d_stream #(.DATA_W(8), .COEF_W(8), .OUT_W(16), .IMG_W(IW), .IMG_H(IH), .K(3), .SHIFT(0), .RELU(0)) u_base (
      .clk(clk), .rst_n(rst_n), .en(en), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .busy(busy_b), .strm(if_b));
   conv2d_stream #(.DATA_W(8), .COEF_W(8), .OUT_W(16), .IMG_W(IW), .IMG_H(IH), .K(3), .SHIFT(0), .RELU(1)) u_relu (
      .clk(clk), .rst_n(rst_n), .en(en), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .busy(busy_r), .strm(if_r));
   conv2d_stream #(.DATA_W(8), .COEF_W(8), .OUT_W(16), .IMG_W(IW), .IMG_H(IH), .K(3), .SHIFT(4), .RELU(0)) u_sh4 (
      .clk(clk), .rst_n(rst_n), .en(en), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .busy(busy_s), .strm(if_s));

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Direct convolution of the k-th valid window in raster order, then shift/ReLU/clamp.
   function automatic int model_px(input int k, input int shift, input int relu);
      int r0, c0, acc;
      r0  = k / 3;
      c0  = k % 3;
      acc = 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) acc += img[(r0 + i) * IW + c0 + j] * kc[i * 3 + j];
      acc = acc >>> shift;
      if (relu != 0 && acc < 0) acc = 0;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      return acc;
   endfunction

   task automatic load_kc();
      en = 1'b0;
      for (int i = 0; i < 9; i++) begin
         coef_we   = 1'b1;
         coef_addr = 4'(i);
         coef_data = 8'(kc[i]);
         @(negedge clk);
      end
      coef_we = 1'b0;
   endtask

   task automatic set_kc(input int v);
      for (int i = 0; i < 9; i++) kc[i] = v;
   endtask

   // mode 0: constant val, 1: r*IW+c, 2: random. Called and returns at a falling edge (+1 when aborted).
   task automatic run_frame(input int mode, input int val, input bit stalls, input bit rnd,
                            input int abort_at, output bit aborted);
      int  sent, k, cyc;
      bit  held, held_last;
      logic signed [15:0] held_pix;
      sent = 0; k = 0; cyc = 0; held = 0; held_last = 0; held_pix = '0; aborted = 0;
      for (int i = 0; i < NPIX; i++)
         img[i] = (mode == 0) ? val : (mode == 1) ? i : int'($urandom_range(0, 255));
      while (cyc < LIMIT) begin
         en        = rnd ? ($urandom_range(0, 3) != 0) : !(stalls && cyc >= 9 && cyc < 12);
         out_ready = rnd ? ($urandom_range(0, 2) != 0) : (stalls ? (cyc % 2 == 0) : 1'b1);
         coef_we   = stalls && (cyc == 14);
         coef_addr = 4'd4;
         coef_data = 8'hCE;
         in_valid  = (sent < NPIX) && (!rnd || $urandom_range(0, 3) != 0);
         in_pix    = (sent < NPIX) ? 8'(img[sent]) : 8'd0;
         #1;
         if (held) begin
            chk("hold_valid", if_b.out_valid, 1);
            chk("hold_pix", if_b.out_pix, held_pix);
            chk("hold_last", if_b.out_last, held_last);
         end
         held      = if_b.out_valid && !out_ready;
         held_pix  = if_b.out_pix;
         held_last = if_b.out_last;
         if (if_b.out_valid && out_ready) begin
            if (k >= NOUT) begin
               chk("extra_out", k, NOUT - 1);
            end else begin
               chk("pix_base", if_b.out_pix, model_px(k, 0, 0));
               chk("pix_relu", if_r.out_pix, model_px(k, 0, 1));
               chk("pix_sh4",  if_s.out_pix, model_px(k, 4, 0));
               chk("last",     if_b.out_last, (k == NOUT - 1));
               chk("sync_valid", {if_r.out_valid, if_s.out_valid}, 2'b11);
            end
            k++;
         end
         if (in_valid && if_b.in_ready) sent++;
         if (abort_at >= 0 && k == abort_at) begin
            aborted = 1;
            break;
         end
         if (sent == NPIX && k >= NOUT && !busy_b) break;
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      en = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
      if (!aborted) begin
         chk("no_timeout", (cyc < LIMIT), 1);
         chk("n_out", k, NOUT);
         chk("n_in", sent, NPIX);
         chk("busy_end", {busy_b, busy_r, busy_s}, 3'b000);
         chk("ready_end", if_b.in_ready, 0);
      end
   endtask

   initial begin
      en = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", if_b.out_valid, 0);
      chk("rst_out_pix", if_b.out_pix, 0);
      chk("rst_out_last", if_b.out_last, 0);
      chk("rst_in_ready", {if_b.in_ready, if_r.in_ready, if_s.in_ready}, 3'b000);
      chk("rst_busy", {busy_b, busy_r, busy_s}, 3'b000);
      en = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", if_b.in_ready, 0);

      set_kc(1); load_kc();
      run_frame(0, 1, 0, 0, -1, ab);

      set_kc(0); kc[4] = 1; load_kc();
      run_frame(1, 0, 0, 0, -1, ab);
      run_frame(1, 0, 1, 0, -1, ab);

      set_kc(-1); load_kc();
      run_frame(0, 1, 0, 0, -1, ab);

      set_kc(127); load_kc();
      run_frame(0, 255, 0, 0, -1, ab);

      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 9; i++) kc[i] = int'($urandom_range(0, 255)) - 128;
         load_kc();
         run_frame(2, 0, 0, 1, -1, ab);
      end

      set_kc(1); load_kc();
      run_frame(0, 1, 0, 0, 4, ab);
      chk("abort_reached", ab, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", if_b.out_valid, 0);
      chk("arst_out_pix", if_b.out_pix, 0);
      chk("arst_in_ready", if_b.in_ready, 0);
      chk("arst_busy", busy_b, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      set_kc(0);
      run_frame(0, 1, 0, 0, -1, ab);
      set_kc(1); load_kc();
      run_frame(0, 1, 0, 0, -1, ab);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
